// File: rtl/cla_slice_sequencer_if.sv
// Request/response bundle for cla_slice_sequencer.
//   master : requester side. It drives in_valid, a, b, op, c_in and out_ready.
//            It observes in_ready, out_valid, result, carry, overflow, zero and busy.
//   slave  : adder side. It has the opposite directions.
interface cla_slice_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, a, b, op, c_in, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, busy
    );

    modport slave (
        input  in_valid, a, b, op, c_in, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, busy
    );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Multi-cycle add/subtract unit.
// One SLICE-bit carry-lookahead adder is shared across a WIDTH-bit operation.
// Slices are processed LSB-first, and each slice's carry-out is registered
// into the next slice.
// Ports:
//   clk  : rising-edge clock.
//   rst  : synchronous, active-high reset.
//   bus  : slave modport of cla_slice_sequencer_if.
//          Request side:  in_valid/in_ready, a, b, op, c_in.
//          Response side: out_valid/out_ready, result, carry, overflow, zero, busy.
//   op encoding: 00 ADD, 01 SUB, 10 ADC, 11 SBC.
module cla_slice_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_slice_sequencer_if.slave  bus
);
    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int NUM_GROUPS = SLICE / 4;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic             cin_reg;

    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic             overflow_r;
    logic             zero_r;

    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;
    logic [SLICE-1:0] slice_sum;
    logic [WIDTH-1:0] next_result;

    // This function computes the generate term of a 4-bit group.
    function automatic logic group_gen(input logic [3:0] gp, input logic [3:0] gg);
        return gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]);
    endfunction

    // This function computes the propagate term of a 4-bit group.
    function automatic logic group_prop(input logic [3:0] gp);
        return &gp;
    endfunction

    // Slice adder.
    // Inside each group, the carries come from p/g and the group carry-in only.
    // The groups are chained through their G/P terms.
    always_comb begin
        a_s  = a_reg[idx*SLICE +: SLICE];
        b_s  = b_reg[idx*SLICE +: SLICE];
        p    = a_s ^ b_s;
        g    = a_s & b_s;
        c    = '0;
        c[0] = cin_reg;
        for (int grp = 0; grp < NUM_GROUPS; grp++) begin
            c[4*grp+1] = g[4*grp] | (p[4*grp] & c[4*grp]);
            c[4*grp+2] = g[4*grp+1] | (p[4*grp+1] & g[4*grp])
                       | (p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+3] = g[4*grp+2] | (p[4*grp+2] & g[4*grp+1])
                       | (p[4*grp+2] & p[4*grp+1] & g[4*grp])
                       | (p[4*grp+2] & p[4*grp+1] & p[4*grp] & c[4*grp]);
            c[4*grp+4] = group_gen(p[4*grp +: 4], g[4*grp +: 4])
                       | (group_prop(p[4*grp +: 4]) & c[4*grp]);
        end
        slice_sum   = p ^ c[SLICE-1:0];
        next_result = result_r;
        next_result[idx*SLICE +: SLICE] = slice_sum;
    end

    // Operands are captured only at the accept edge.
    // B is stored pre-inverted for subtract ops.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.op[0] ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            result_r    <= '0;
            carry_r     <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            idx         <= '0;
            cin_reg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        idx        <= '0;
                        // The carry-in is 1 for SUB, c_in for ADC/SBC and 0 for ADD.
                        cin_reg    <= bus.op[1] ? bus.c_in : bus.op[0];
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    result_r <= next_result;
                    cin_reg  <= c[SLICE];
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        carry_r     <= c[SLICE];
                        overflow_r  <= c[SLICE] ^ c[SLICE-1];
                        zero_r      <= (next_result == '0);
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    // A new request cannot be accepted in the same cycle
                    // that the result is consumed.
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.result    = result_r;
    assign bus.carry     = carry_r;
    assign bus.overflow  = overflow_r;
    assign bus.zero      = zero_r;
endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Multi-cycle add/subtract controller that time-shares one SLICE-bit carry-lookahead adder slice across a WIDTH-bit operation.
- Processes slices LSB-first and registers each slice's carry into the next slice.
- Used by the RISC datapath as a low-area ALU adder path with a valid/ready handshake on both sides.
- The slice adder is built from 4-bit lookahead groups chained by group generate/propagate.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE.
- SLICE, 8, bits processed per cycle; must be a multiple of 4. NUM_SLICES = WIDTH/SLICE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+c_in), 11 SBC (a+~b+c_in).
- c_in  input  1  carry-in; used only by ADC and SBC.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum.
- carry  output  1  carry out of bit WIDTH-1; for SUB/SBC, 1 means no borrow.
- overflow  output  1  signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- zero  output  1  result == 0.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-RUN: state=IDLE, in_ready=1, out_valid=0, busy=0. result, carry, overflow and zero all reset to 0. The slice index and carry register clear, and any partial operation is discarded.
- IDLE state:
  - in_ready=1.
  - A request is accepted at an edge where in_valid=1.
  - On acceptance, latch a, b (B is inverted when op[0]=1), the slice carry (1 for SUB, c_in for ADC/SBC, 0 for ADD), and idx=0.
  - Next state is RUN.
- RUN state:
  - in_ready=0, busy=1.
  - Each cycle, present slice idx of A and B' plus the carry register to the CLA slice.
  - At the edge, write the slice sum into result[idx*SLICE +: SLICE], load the slice carry-out into the carry register, and increment idx.
  - On the final slice (idx=NUM_SLICES-1), also capture carry and overflow and compute zero from the full result.
  - Next state is DONE.
- DONE state:
  - out_valid=1, in_ready=0.
  - result and all flags are held stable while out_ready=0.
  - At an edge with out_ready=1, go to IDLE. There is no same-cycle new accept.
- Latency:
  - Accept at edge E gives out_valid=1 after edge E+NUM_SLICES (4 edges for the defaults).
  - Throughput is at most one operation per NUM_SLICES+2 cycles.
- Input handling:
  - in_valid and operand changes outside IDLE are ignored.
  - Operands are sampled only at the accept edge.
- Result visibility: result bits of unfinished slices hold the previous operation's values during RUN and are not valid until out_valid=1.
- Lookahead rule within a slice:
  - Each 4-bit group forms internal carries c1..c3 from p/g and the group carry-in.
  - Each group's carry-out = G + P*cin, where G is the group generate and P the group propagate.
  - Groups are chained combinationally inside the slice.
- Wrap-around: the carry out of the MSB never feeds back into result; the final sum is modulo 2^WIDTH.
- Flags are updated only on the final slice and otherwise retain their last values.

Test Plan:
- ADD 0x000000FF + 0x00000001, with out_ready=1 → result=0x00000100, carry=0, overflow=0, zero=0; out_valid rises exactly 4 edges after accept.
- ADD 0xFFFFFFFF + 0x00000001 → result=0x00000000, carry=1, zero=1, overflow=0. This checks the carry chained through all 4 slices.
- SUB 5 − 7 → 0xFFFFFFFE, carry=0, overflow=0. Then SUB 0x80000000 − 1 → 0x7FFFFFFF, carry=1, overflow=1.
- ADC 0x7FFFFFFF + 0 with c_in=1 → 0x80000000, overflow=1, carry=0. Then SBC 10 − 3 with c_in=0 → 6, carry=1.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid=1 with new operands. result and flags must not change, in_ready stays 0, and the new operands are not accepted. Raise out_ready: one cycle later the block is in IDLE and accepts the next request.
- Reset mid-RUN: assert rst after slice 1. Next cycle all outputs are 0 and in_ready=1. A following ADD 2+3 returns 5 with normal latency.
